// File: rtl/core_issue_buffer_pkg.sv
// Shared types and helpers for the in-order issue staging buffer.
package core_issue_buffer_pkg;

    localparam int INST_WIDTH = 128;

    typedef logic [INST_WIDTH-1:0] inst_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/core_issue_buffer_lead_ones.sv
// Leading-ones counter: number of contiguous set bits starting at bit 0.
module lead_ones_count #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]               vec,
    output logic [$clog2(WIDTH+1)-1:0]     cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            run = run & vec[i];
            if (run) begin
                cnt = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/core_issue_buffer.sv
// In-order issue staging buffer: compacts issued slots every cycle and refills
// from the decoder FIFO with the space that remains.
module core_issue_buffer
    import core_issue_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = INST_WIDTH,
    parameter int ISSUE_WIDTH = 2,
    parameter int SLOTS       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 hold_i,
    input  logic [ISSUE_WIDTH-1:0]               in_valid_i,
    input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    in_data_i,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]     in_num_o,
    output logic [ISSUE_WIDTH-1:0]               out_valid_o,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    out_data_o,
    input  logic [ISSUE_WIDTH-1:0]               issue_i,
    output logic [$clog2(SLOTS+1)-1:0]           count_o
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam int IW = $clog2(ISSUE_WIDTH + 1);

    typedef logic [CW-1:0] slot_cnt_t;
    typedef logic [IW-1:0] issue_cnt_t;

    generate
        if (SLOTS < ISSUE_WIDTH) begin : g_bad_slots
            $error("core_issue_buffer: SLOTS must be >= ISSUE_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]  slot_q [SLOTS];
    logic [DATA_WIDTH-1:0]  slot_d [SLOTS];
    slot_cnt_t              count_q;
    slot_cnt_t              count_d;
    slot_cnt_t              remain;
    slot_cnt_t              space;
    slot_cnt_t              take;
    issue_cnt_t             issued;
    issue_cnt_t             in_cnt;
    logic [ISSUE_WIDTH-1:0] issue_ok;
    logic [ISSUE_WIDTH-1:0] issue_inc;

    genvar k;
    generate
        for (k = 0; k < ISSUE_WIDTH; k++) begin : g_out
            assign out_valid_o[k]                           = (CW'(k) < count_q);
            assign out_data_o[k*DATA_WIDTH +: DATA_WIDTH]  = slot_q[k];
        end
    endgenerate

    assign count_o   = count_q;
    assign issue_ok  = issue_i & out_valid_o;
    assign issue_inc = issue_i + ISSUE_WIDTH'(1);

    lead_ones_count #(.WIDTH(ISSUE_WIDTH)) u_issue_cnt (
        .vec (issue_ok),
        .cnt (issued)
    );

    lead_ones_count #(.WIDTH(ISSUE_WIDTH)) u_in_cnt (
        .vec (in_valid_i),
        .cnt (in_cnt)
    );

    // Intake uses space freed by this cycle's issue, so a full buffer that
    // issues can refill in the same cycle.
    always_comb begin
        remain = count_q - CW'(issued);
        space  = CW'(SLOTS) - remain;
        take   = CW'(min_int(int'(in_cnt), int'(space)));
        if (take > CW'(ISSUE_WIDTH)) begin
            take = CW'(ISSUE_WIDTH);
        end
        if (rst || flush_i || hold_i) begin
            in_num_o = '0;
        end else begin
            in_num_o = IW'(take);
        end
    end

    always_comb begin
        for (int j = 0; j < SLOTS; j++) begin
            slot_d[j] = slot_q[j];
            for (int s = 0; s < SLOTS; s++) begin
                if ((j < int'(remain)) && (s == j + int'(issued))) begin
                    slot_d[j] = slot_q[s];
                end
            end
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if ((i < int'(in_num_o)) && (j == int'(remain) + i)) begin
                    slot_d[j] = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (rst || flush_i) begin
            count_d = '0;
        end else begin
            count_d = remain + CW'(in_num_o);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Slot payloads carry no reset; only count_q qualifies them.
    always_ff @(posedge clk) begin
        for (int j = 0; j < SLOTS; j++) begin
            slot_q[j] <= slot_d[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((issue_i & issue_inc) == '0)
                else $error("core_issue_buffer: non-prefix issue_i %b", issue_i);
            assert ((issue_i & ~out_valid_o) == '0)
                else $error("core_issue_buffer: issue on invalid lane %b/%b", issue_i, out_valid_o);
        end
    end

endmodule

// File: tb/tb_core_issue_buffer.sv
// Bench for core_issue_buffer: directed vector table on a 2-lane/4-slot build,
// randomized queue-model comparison on a 4-lane/8-slot build.
module tb_core_issue_buffer;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 2-lane / 4-slot instance
    logic          a_rst, a_flush, a_hold;
    logic [1:0]    a_in_valid, a_issue, a_out_valid, a_in_num;
    logic [2*DW-1:0] a_in_data, a_out_data;
    logic [2:0]    a_count;

    core_issue_buffer #(.DATA_WIDTH(DW), .ISSUE_WIDTH(2), .SLOTS(4)) u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .flush_i     (a_flush),
        .hold_i      (a_hold),
        .in_valid_i  (a_in_valid),
        .in_data_i   (a_in_data),
        .in_num_o    (a_in_num),
        .out_valid_o (a_out_valid),
        .out_data_o  (a_out_data),
        .issue_i     (a_issue),
        .count_o     (a_count)
    );

    // 4-lane / 8-slot instance
    logic          b_rst, b_flush, b_hold;
    logic [3:0]    b_in_valid, b_issue, b_out_valid;
    logic [2:0]    b_in_num;
    logic [4*DW-1:0] b_in_data, b_out_data;
    logic [3:0]    b_count;

    core_issue_buffer #(.DATA_WIDTH(DW), .ISSUE_WIDTH(4), .SLOTS(8)) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .flush_i     (b_flush),
        .hold_i      (b_hold),
        .in_valid_i  (b_in_valid),
        .in_data_i   (b_in_data),
        .in_num_o    (b_in_num),
        .out_valid_o (b_out_valid),
        .out_data_o  (b_out_data),
        .issue_i     (b_issue),
        .count_o     (b_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        hold;
        logic [1:0]  in_valid;
        logic [1:0]  issue;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  exp_num;
        logic [2:0]  exp_cnt;
        logic [1:0]  exp_ov;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
    } vec_t;

    localparam logic [15:0] DA = 16'h000A, DB = 16'h000B, DC = 16'h000C, DD = 16'h000D,
                            DE = 16'h000E, DF = 16'h000F, DG = 16'h0010, DH = 16'h0011,
                            DI = 16'h0012, DJ = 16'h0013, DK = 16'h0014, DL = 16'h0015,
                            DM = 16'h0016, DN = 16'h0017, DP = 16'h0018, DQ = 16'h0019,
                            DR = 16'h001A, DS = 16'h001B;

    localparam int NV = 19;
    vec_t tbl [NV];

    int unsigned q [$];
    logic [15:0] seq;
    int          nin, niss, vis, exp_num, space;

    initial begin
        //            rst  fl   hd   iv     iss    d0  d1  num cnt  ov     ed0 ed1
        tbl[0]  = '{1'b0,1'b0,1'b0,2'b11,2'b00, DA, DB, 2, 3'd2,2'b11, DA, DB};
        tbl[1]  = '{1'b0,1'b0,1'b0,2'b11,2'b00, DC, DD, 2, 3'd4,2'b11, DA, DB};
        tbl[2]  = '{1'b0,1'b0,1'b0,2'b11,2'b00, DE, DF, 0, 3'd4,2'b11, DA, DB};
        tbl[3]  = '{1'b0,1'b0,1'b0,2'b11,2'b01, DE, DF, 1, 3'd4,2'b11, DB, DC};
        tbl[4]  = '{1'b0,1'b0,1'b0,2'b00,2'b11, DF, DF, 0, 3'd2,2'b11, DD, DE};
        tbl[5]  = '{1'b0,1'b0,1'b0,2'b01,2'b00, DG, DF, 1, 3'd3,2'b11, DD, DE};
        tbl[6]  = '{1'b0,1'b0,1'b0,2'b11,2'b11, DH, DI, 2, 3'd3,2'b11, DG, DH};
        tbl[7]  = '{1'b0,1'b1,1'b0,2'b11,2'b11, DJ, DK, 0, 3'd0,2'b00, DA, DA};
        tbl[8]  = '{1'b0,1'b0,1'b0,2'b11,2'b00, DL, DM, 2, 3'd2,2'b11, DL, DM};
        tbl[9]  = '{1'b0,1'b0,1'b0,2'b11,2'b00, DN, DP, 2, 3'd4,2'b11, DL, DM};
        tbl[10] = '{1'b0,1'b0,1'b1,2'b11,2'b11, DA, DB, 0, 3'd2,2'b11, DN, DP};
        tbl[11] = '{1'b0,1'b0,1'b1,2'b11,2'b11, DA, DB, 0, 3'd0,2'b00, DA, DA};
        tbl[12] = '{1'b0,1'b0,1'b1,2'b11,2'b00, DA, DB, 0, 3'd0,2'b00, DA, DA};
        tbl[13] = '{1'b0,1'b1,1'b1,2'b11,2'b00, DA, DB, 0, 3'd0,2'b00, DA, DA};
        tbl[14] = '{1'b0,1'b0,1'b0,2'b01,2'b00, DQ, DB, 1, 3'd1,2'b01, DQ, DA};
        tbl[15] = '{1'b0,1'b0,1'b0,2'b10,2'b00, DR, DS, 0, 3'd1,2'b01, DQ, DA};
        tbl[16] = '{1'b0,1'b0,1'b0,2'b11,2'b01, DR, DS, 2, 3'd2,2'b11, DR, DS};
        tbl[17] = '{1'b1,1'b0,1'b0,2'b11,2'b11, DA, DB, 0, 3'd0,2'b00, DA, DA};
        tbl[18] = '{1'b0,1'b0,1'b0,2'b11,2'b00, DC, DD, 2, 3'd2,2'b11, DC, DD};

        a_rst = 1'b1; a_flush = 1'b0; a_hold = 1'b0;
        a_in_valid = '0; a_issue = '0; a_in_data = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_hold = 1'b0;
        b_in_valid = '0; b_issue = '0; b_in_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.count_o", 64'(a_count), 64'd0);
        check("reset.out_valid", 64'(a_out_valid), 64'd0);
        check("reset.in_num", 64'(a_in_num), 64'd0);

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            a_rst      = tbl[v].rst;
            a_flush    = tbl[v].flush;
            a_hold     = tbl[v].hold;
            a_in_valid = tbl[v].in_valid;
            a_issue    = tbl[v].issue;
            a_in_data  = {tbl[v].d1, tbl[v].d0};
            #1;
            check($sformatf("tbl[%0d].in_num", v), 64'(a_in_num), 64'(tbl[v].exp_num));
            @(posedge clk);
            #1;
            check($sformatf("tbl[%0d].count", v), 64'(a_count), 64'(tbl[v].exp_cnt));
            check($sformatf("tbl[%0d].out_valid", v), 64'(a_out_valid), 64'(tbl[v].exp_ov));
            if (tbl[v].exp_ov[0])
                check($sformatf("tbl[%0d].lane0", v), 64'(a_out_data[15:0]), 64'(tbl[v].exp_d0));
            if (tbl[v].exp_ov[1])
                check($sformatf("tbl[%0d].lane1", v), 64'(a_out_data[31:16]), 64'(tbl[v].exp_d1));
        end

        @(negedge clk);
        a_in_valid = '0; a_issue = '0; a_flush = 1'b0; a_hold = 1'b0;
        b_rst = 1'b0;
        seq = 16'd1;

        for (int cyc = 0; cyc < 500; cyc++) begin
            b_flush = ($urandom_range(0, 15) == 0);
            b_hold  = ($urandom_range(0, 7) == 0);
            nin     = $urandom_range(0, 4);
            b_in_valid = '0;
            for (int i = 0; i < nin; i++) b_in_valid[i] = 1'b1;
            for (int i = 0; i < 4; i++)
                b_in_data[i*DW +: DW] = (i < nin) ? seq + 16'(i) : 16'($urandom);
            vis  = (q.size() < 4) ? q.size() : 4;
            niss = $urandom_range(0, vis);
            b_issue = '0;
            for (int i = 0; i < niss; i++) b_issue[i] = 1'b1;

            space   = 8 - (q.size() - niss);
            exp_num = (b_flush || b_hold) ? 0 : ((nin < space) ? nin : space);
            #1;
            check($sformatf("rnd[%0d].in_num", cyc), 64'(b_in_num), 64'(exp_num));

            if (b_flush) begin
                q.delete();
            end else begin
                for (int i = 0; i < niss; i++) void'(q.pop_front());
                for (int i = 0; i < exp_num; i++) q.push_back(int'(seq) + i);
            end
            seq = seq + 16'(exp_num);

            @(posedge clk);
            #1;
            check($sformatf("rnd[%0d].count", cyc), 64'(b_count), 64'(q.size()));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rnd[%0d].valid%0d", cyc, i), 64'(b_out_valid[i]),
                      64'(i < q.size()));
                if (i < q.size())
                    check($sformatf("rnd[%0d].lane%0d", cyc, i),
                          64'(b_out_data[i*DW +: DW]), 64'(q[i][15:0]));
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
